// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the md unit state encoding, op codes, default latencies and the register-match helper.
package hazard_stall_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdState_t;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    localparam int DEFAULT_MULT_LAT = 5;
    localparam int DEFAULT_DIV_LAT  = 10;
    localparam int DEFAULT_CNT_W    = 4;

    // $0 is hardwired to zero, so a write to it can never create a dependency.
    function automatic logic regMatch(input logic [4:0] dst,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt);
        return (dst != 5'd0) && ((dst == rs) || (dst == rt));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage fields in, stall/flush and md status out.
interface hazard_stall_ctrl_if
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic [4:0]       rsD;
    logic [4:0]       rtD;
    logic             BranchD;
    logic             mdUseD;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic [4:0]       WriteRegE;
    logic             RegWriteM;
    logic             MemtoRegM;
    logic [4:0]       WriteRegM;
    logic             mdStartE;
    logic             mdOpE;
    logic             stallF;
    logic             stallD;
    logic             flushE;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] md_cnt;

    modport master (
        output rsD, rtD, BranchD, mdUseD,
        output RegWriteE, MemtoRegE, WriteRegE,
        output RegWriteM, MemtoRegM, WriteRegM,
        output mdStartE, mdOpE,
        input  stallF, stallD, flushE,
        input  md_busy, md_done, md_cnt
    );

    modport slave (
        input  rsD, rtD, BranchD, mdUseD,
        input  RegWriteE, MemtoRegE, WriteRegE,
        input  RegWriteM, MemtoRegM, WriteRegM,
        input  mdStartE, mdOpE,
        output stallF, stallD, flushE,
        output md_busy, md_done, md_cnt
    );

endinterface

// File: rtl/hazard_stall_ctrl_md_latency_counter.sv
// Latency sequencer for the multi-cycle mult/div unit: counts down the busy window
// after an accepted start and pulses done in the final busy cycle.
module hazard_stall_ctrl_md_latency_counter
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = DEFAULT_MULT_LAT,
    parameter int DIV_LAT  = DEFAULT_DIV_LAT,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdStartE,
    input  logic             mdOpE,
    output logic             mdBusy,
    output logic             mdDone,
    output logic [CNT_W-1:0] mdCnt
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    mdState_t         state;
    logic [CNT_W-1:0] loadCnt;

    assign loadCnt = (mdOpE == MD_OP_DIV) ? DIV_CNT : MULT_CNT;
    assign mdBusy  = (state == BUSY);

    // Starts are only honoured from IDLE; done is precomputed so it is high exactly while the count reads 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mdCnt  <= '0;
            mdDone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdStartE) begin
                        state  <= BUSY;
                        mdCnt  <= loadCnt;
                        mdDone <= (loadCnt == CNT_ONE);
                    end
                end
                BUSY: begin
                    if (mdCnt == CNT_ONE) begin
                        state  <= IDLE;
                        mdCnt  <= '0;
                        mdDone <= 1'b0;
                    end else begin
                        mdCnt  <= mdCnt - CNT_ONE;
                        mdDone <= (mdCnt == CNT_TWO);
                    end
                end
                default: begin
                    state  <= IDLE;
                    mdCnt  <= '0;
                    mdDone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central hazard/stall controller for the 5-stage pipeline: load-use, branch-operand
// and mult/div hazards combine into one zero-latency stall that also bubbles E.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = DEFAULT_MULT_LAT,
    parameter int DIV_LAT  = DEFAULT_DIV_LAT,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input logic                clk,
    input logic                reset,
    hazard_stall_ctrl_if.slave bus
);

    logic             lwStall;
    logic             brStall;
    logic             mdStall;
    logic             stall;
    logic             mdBusy;
    logic             mdDone;
    logic [CNT_W-1:0] mdCnt;
    logic             unusedRegWriteM;

    assign unusedRegWriteM = bus.RegWriteM;

    // A branch resolves in D, so it must wait for any E-stage writer and for a load still in M.
    always_comb begin
        lwStall = bus.MemtoRegE & regMatch(bus.WriteRegE, bus.rsD, bus.rtD);
        brStall = bus.BranchD &
                  ((bus.RegWriteE & regMatch(bus.WriteRegE, bus.rsD, bus.rtD)) |
                   (bus.MemtoRegM & regMatch(bus.WriteRegM, bus.rsD, bus.rtD)));
        mdStall = bus.mdUseD & (mdBusy | bus.mdStartE);
        stall   = lwStall | brStall | mdStall;
    end

    hazard_stall_ctrl_md_latency_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) mdCounter (
        .clk      (clk),
        .reset    (reset),
        .mdStartE (bus.mdStartE),
        .mdOpE    (bus.mdOpE),
        .mdBusy   (mdBusy),
        .mdDone   (mdDone),
        .mdCnt    (mdCnt)
    );

    assign bus.stallF  = stall;
    assign bus.stallD  = stall;
    assign bus.flushE  = stall;
    assign bus.md_busy = mdBusy;
    assign bus.md_done = mdDone;
    assign bus.md_cnt  = mdCnt;

endmodule
